// File: rtl/seq_unsigned_divider.sv
// Sequential restoring divider. Each BUSY cycle produces one quotient bit, MSB first.
// A zero divisor skips the iterations and flags div_by_zero.
module seq_unsigned_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] dvd_q;   // shifts dividend bits out and quotient bits in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // A failed trial subtraction only happens when shifted < divisor, so
  // shifted[WIDTH] is zero whenever the restored value is kept.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = (dvd_q << 1) | WIDTH'(q_bit);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      ready       <= 1'b1;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              ready       <= 1'b1;
              state       <= DONE;
            end else begin
              done  <= 1'b0;
              ready <= 1'b0;
              state <= BUSY;
            end
          end else begin
            done  <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end

        BUSY: begin
          rem_q <= rem_next;
          dvd_q <= quo_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            quotient    <= quo_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            ready       <= 1'b1;
            state       <= DONE;
          end
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Scoreboard bench for seq_unsigned_divider (WIDTH=8): stimulus pushes expected
// results, a monitor pops and compares on every done pulse.
module tb_seq_unsigned_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         start = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         ready;
  logic         done;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  seq_unsigned_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .dividend   (dividend),
    .divisor    (divisor),
    .start      (start),
    .quotient   (quotient),
    .remainder  (remainder),
    .ready      (ready),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", div_by_zero, e.z);
        end
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", ready, 1);
  endtask

  // Issue one operation, check its latency profile, scramble operands while busy.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    wait_ready();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push(eq, er, ez);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (b == '0) begin
      @(negedge clk);
      check("dbz_done_latency", done, 1);
      check("dbz_ready", ready, 1);
    end else begin
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        dividend = ~a;
        divisor  = b + 8'd1;
        check("busy_ready_low", ready, 0);
        check("busy_no_done", done, 0);
      end
      @(negedge clk);
      check("done_latency", done, 1);
      check("done_ready", ready, 1);
    end
  endtask

  initial begin
    logic [W-1:0] a, b;

    // Reset held for two edges with a start request pending.
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ready, 1);
    check("post_rst_done", done, 0);

    // Basic and boundary vectors.
    issue(8'd200, 8'd7,   8'd28,  8'd4,   1'b0);
    issue(8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
    issue(8'd5,   8'd9,   8'd0,   8'd5,   1'b0);
    issue(8'd0,   8'd3,   8'd0,   8'd0,   1'b0);
    issue(8'd255, 8'd255, 8'd1,   8'd0,   1'b0);

    // Divide by zero, then a normal op clears the flag.
    issue(8'd123, 8'd0,   8'd255, 8'd123, 1'b1);
    issue(8'd10,  8'd3,   8'd3,   8'd1,   1'b0);

    // Handshake: start during BUSY is ignored; start held in DONE is accepted.
    wait_ready();
    dividend = 8'd100;
    divisor  = 8'd9;
    start    = 1'b1;
    push(8'd11, 8'd1, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("hs_busy_ready", ready, 0);
      start    = 1'b1;
      dividend = 8'd50 + 8'(i);
      divisor  = 8'd5;
    end
    @(negedge clk);
    check("hs_done", done, 1);
    dividend = 8'd77;
    divisor  = 8'd8;
    push(8'd9, 8'd5, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("b2b_busy_ready", ready, 0);
      check("b2b_hold_quotient", quotient, 11);
    end
    @(negedge clk);
    check("b2b_done", done, 1);

    // Reset on the third BUSY cycle aborts with no done pulse.
    wait_ready();
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", ready, 1);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    repeat (12) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end

    // Random operands against an arithmetic reference.
    for (int n = 0; n < 500; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (b == '0) issue(a, b, 8'd255, a, 1'b1);
      else         issue(a, b, a / b, a % b, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_unsigned_divider.md
SEQ_UNSIGNED_DIVIDER -- requirements
Module: seq_unsigned_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port dividend, input, WIDTH, unsigned numerator, sampled only on an accepted start.
REQ-005 SHALL have port divisor, input, WIDTH, unsigned denominator, sampled only on an accepted start.
REQ-006 SHALL have port start, input, 1, operation request.
REQ-007 SHALL have port quotient, output, WIDTH, registered result quotient.
REQ-008 SHALL have port remainder, output, WIDTH, registered result remainder.
REQ-009 SHALL have port ready, output, 1, high when not busy, so a start is accepted.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking the cycle new results first appear.
REQ-011 SHALL have port div_by_zero, output, 1, flag qualifying the current results.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, BUSY and DONE; ready=1 in IDLE and DONE, ready=0 in BUSY.
REQ-013 SHALL accept start only at a rising edge where ready=1; an accepted start latches dividend and divisor and clears the iteration counter.
REQ-014 SHALL go to BUSY on an accepted start with divisor!=0, and to DONE directly on an accepted start with divisor==0.
REQ-015 SHALL ignore start while in BUSY; operand input changes during BUSY SHALL NOT affect the result.
REQ-016 SHALL perform restoring division with a WIDTH+1-bit partial remainder, producing one quotient bit per cycle, MSB first.
REQ-017 Each BUSY iteration SHALL shift {partial remainder, next dividend bit} left, trial-subtract divisor, keep the difference and set the quotient bit to 1 if non-negative, else restore and set it to 0.
REQ-018 SHALL stay in BUSY for exactly WIDTH cycles: start accepted at edge N gives done=1, ready=1 and valid results in the cycle after edge N+WIDTH.
REQ-019 For divisor==0, SHALL load quotient={WIDTH{1'b1}}, remainder=dividend and div_by_zero=1, with done=1 in the cycle after the accepting edge (latency 1).
REQ-020 For a non-zero divisor, SHALL load div_by_zero=0 together with the result.
REQ-021 SHALL drive done for exactly one cycle (the DONE state); DONE SHALL go to IDLE unless start=1, in which case the new operation is accepted (back-to-back, no idle gap).
REQ-022 SHALL update quotient, remainder and div_by_zero only when entering DONE, and SHALL hold them stable in IDLE, BUSY and DONE until the next result.
REQ-023 Results SHALL satisfy quotient*divisor+remainder==dividend and remainder<divisor for all non-zero divisors, including dividend<divisor (quotient=0, remainder=dividend) and dividend==0.
REQ-024 SHALL not use a combinational divide operator; the datapath SHALL be one subtractor of WIDTH+1 bits plus shift registers.

Reset
REQ-025 When rst=1 at a rising edge, SHALL force state IDLE, quotient=0, remainder=0, done=0, div_by_zero=0 and ready=1, with rst taking priority over start.
REQ-026 When rst is asserted mid-operation (BUSY or DONE), SHALL abort the operation with no done pulse; the aborted operation's results SHALL never appear.

Verification
REQ-027 Reset: hold rst=1 for 2 cycles with start=1 -> ready=1, done=0, quotient=0, remainder=0, div_by_zero=0 and no operation started.
REQ-028 Basic (WIDTH=8): start with 200/7 -> ready=0 for 8 cycles, then done=1 for one cycle with quotient=28, remainder=4, div_by_zero=0.
REQ-029 Boundaries: 255/1 -> 255 r0; 5/9 -> 0 r5; 0/3 -> 0 r0; 255/255 -> 1 r0; each with done exactly 8 cycles after start.
REQ-030 Divide by zero: 123/0 -> done in the next cycle, quotient=255, remainder=123, div_by_zero=1; then 10/3 -> 3 r1 with div_by_zero=0.
REQ-031 Handshake: start with 100/9, re-assert start with 50/5 during BUSY and change operands -> result 11 r1 only; start held in the done cycle with 77/8 -> accepted immediately, giving 9 r5 8 cycles later.
REQ-032 Reset mid-op plus random: assert rst on the 3rd BUSY cycle of 200/7 -> no done, outputs 0; then 500 random operand pairs are checked against quotient*divisor+remainder==dividend and remainder<divisor.
